word_unpack_fsm: RTL and testbench

//  Inverse of the byte-to-word packer in the data-transfer path.

---
 rtl/word_unpack_fsm_pkg.sv | 18 +
 rtl/dp_ram_1w1r.sv | 26 ++
 rtl/word_unpack_fsm.sv | 127 ++++++++++++
 tb/tb_word_unpack_fsm.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/word_unpack_fsm_pkg.sv
// Shared definitions for the word-to-byte unpacker: default geometry and
// FSM state encoding.
package word_unpack_fsm_pkg;

    localparam int DEF_N_WORDS = 16;
    localparam int DEF_WORD_W  = 16;
    localparam int DEF_BYTE_W  = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Word memory is writable whenever no conversion is walking through it.
    function automatic logic word_wr_allowed(input logic [1:0] state);
        return (state != ST_CONV);
    endfunction

endpackage

// File: rtl/dp_ram_1w1r.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module dp_ram_1w1r #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/word_unpack_fsm.sv
// Word-to-byte unpacker: loads words, splits each into high/low bytes on an
// op_mode pulse, and serves the bytes through a registered read port.
module word_unpack_fsm
    import word_unpack_fsm_pkg::*;
#(
    parameter int N_WORDS = DEF_N_WORDS,
    parameter int WORD_W  = DEF_WORD_W,
    parameter int BYTE_W  = DEF_BYTE_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WORD_W-1:0]            data_wr,
    input  logic                         wr_en,
    input  logic [$clog2(N_WORDS)-1:0]   wr_add,
    input  logic [$clog2(2*N_WORDS)-1:0] rd_add,
    input  logic                         op_mode,
    output logic [BYTE_W-1:0]            data_out,
    output logic                         done,
    output logic                         busy
);

    localparam int N_BYTES = 2 * N_WORDS;
    localparam int WA_W    = $clog2(N_WORDS);
    localparam int BA_W    = $clog2(N_BYTES);
    localparam logic [BA_W-1:0] CNT_LAST = BA_W'(N_BYTES - 1);
    localparam logic [BA_W-1:0] CNT_ONE  = BA_W'(1);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [BA_W-1:0]   cnt_r;
    logic [BA_W-1:0]   cnt_nxt_s;
    logic              done_r;
    logic              busy_r;
    logic [BYTE_W-1:0] data_out_r;

    logic              word_we_s;
    logic [WORD_W-1:0] word_rd_s;
    logic              byte_we_s;
    logic [BYTE_W-1:0] byte_wr_s;
    logic [BYTE_W-1:0] byte_rd_s;

    dp_ram_1w1r #(
        .DEPTH (N_WORDS),
        .WIDTH (WORD_W)
    ) u_word_mem (
        .clk     (clk),
        .we      (word_we_s),
        .wr_addr (wr_add),
        .wr_data (data_wr),
        .rd_addr (cnt_r[BA_W-1:1]),
        .rd_data (word_rd_s)
    );

    dp_ram_1w1r #(
        .DEPTH (N_BYTES),
        .WIDTH (BYTE_W)
    ) u_byte_mem (
        .clk     (clk),
        .we      (byte_we_s),
        .wr_addr (cnt_r),
        .wr_data (byte_wr_s),
        .rd_addr (rd_add),
        .rd_data (byte_rd_s)
    );

    // Even byte address takes the high half of the word, odd takes the low half.
    always_comb begin
        if (cnt_r[0]) begin
            byte_wr_s = word_rd_s[BYTE_W-1:0];
        end else begin
            byte_wr_s = word_rd_s[WORD_W-1:BYTE_W];
        end
    end

    // Next-state, counter and write-enable decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        byte_we_s   = 1'b0;
        word_we_s   = wr_en & word_wr_allowed(state_r);
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (op_mode) begin
                    state_nxt_s = ST_CONV;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_CONV: begin
                byte_we_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_DONE;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, counter, status flags and read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            data_out_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            done_r     <= (state_nxt_s == ST_DONE);
            busy_r     <= (state_nxt_s == ST_CONV);
            data_out_r <= byte_rd_s;
        end
    end

    assign data_out = data_out_r;
    assign done     = done_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_word_unpack_fsm.sv
// Directed self-checking bench for word_unpack_fsm: inputs change on the
// falling edge, outputs are checked on the following falling edge.
module tb_word_unpack_fsm;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_wr;
    logic        wr_en;
    logic [3:0]  wr_add;
    logic [4:0]  rd_add;
    logic        op_mode;
    logic [7:0]  data_out;
    logic        done;
    logic        busy;

    int n_cmp;
    int n_err;

    word_unpack_fsm dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_wr  (data_wr),
        .wr_en    (wr_en),
        .wr_add   (wr_add),
        .rd_add   (rd_add),
        .op_mode  (op_mode),
        .data_out (data_out),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_add  = a;
        data_wr = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Pulse op_mode (optionally with a same-edge write), then check busy/done
    // after every edge up to E32. With disturb set, a write and a second
    // op_mode arrive mid-conversion and must be ignored.
    task automatic convert(input logic with_wr, input logic [3:0] a,
                           input logic [15:0] d, input logic disturb);
        op_mode = 1'b1;
        wr_en   = with_wr;
        wr_add  = a;
        data_wr = d;
        @(negedge clk);
        op_mode = 1'b0;
        wr_en   = 1'b0;
        chk("e0_busy", {15'd0, busy}, 16'd1);
        chk("e0_done", {15'd0, done}, 16'd0);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k < 32) begin
                chk($sformatf("conv_busy_e%0d", k), {15'd0, busy}, 16'd1);
                chk($sformatf("conv_done_e%0d", k), {15'd0, done}, 16'd0);
            end else begin
                chk("e32_busy", {15'd0, busy}, 16'd0);
                chk("e32_done", {15'd0, done}, 16'd1);
            end
            if (disturb && k == 5) begin
                wr_en   = 1'b1;
                wr_add  = 4'd3;
                data_wr = 16'hFFFF;
                op_mode = 1'b1;
            end else begin
                wr_en   = 1'b0;
                op_mode = 1'b0;
            end
        end
    endtask

    task automatic read_check(input logic [4:0] a, input logic [7:0] exp);
        rd_add = a;
        @(negedge clk);
        chk($sformatf("rd_byte%0d", a), {8'd0, data_out}, {8'd0, exp});
    endtask

    // Load word[i] = {4i+1, 4i+3}, with word 15 written on the start edge.
    task automatic full_run;
        for (int i = 0; i < 15; i++) begin
            write_word(4'(i), {8'(4 * i + 1), 8'(4 * i + 3)});
        end
        convert(1'b1, 4'd15, {8'd61, 8'd63}, 1'b0);
        for (int j = 0; j < 32; j++) begin
            read_check(5'(j), 8'(2 * j + 1));
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        data_wr = 16'd0;
        wr_en   = 1'b0;
        wr_add  = 4'd0;
        rd_add  = 5'd0;
        op_mode = 1'b0;

        // Reset held for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rst_data_out", {8'd0, data_out}, 16'd0);
            chk("rst_done", {15'd0, done}, 16'd0);
            chk("rst_busy", {15'd0, busy}, 16'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        full_run();

        // Mid-conversion write and op_mode must be ignored.
        convert(1'b0, 4'd0, 16'd0, 1'b1);
        read_check(5'd6, 8'd13);
        read_check(5'd7, 8'd15);
        read_check(5'd0, 8'd1);

        // Asynchronous abort at E10.
        op_mode = 1'b1;
        @(negedge clk);
        op_mode = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_done", {15'd0, done}, 16'd0);
        chk("abort_busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_busy", {15'd0, busy}, 16'd0);
        full_run();

        // Restart from DONE with one rewritten word.
        write_word(4'd0, 16'hA55A);
        convert(1'b0, 4'd0, 16'd0, 1'b0);
        read_check(5'd0, 8'hA5);
        read_check(5'd1, 8'h5A);
        read_check(5'd2, 8'd5);
        read_check(5'd3, 8'd7);
        read_check(5'd31, 8'd63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
